tcdm_bank_adapter: RTL and testbench
====================================

# tcdm_bank_adapter

Target-side adapter sitting directly downstream of the variable-latency interconnect, one instance per target port. Converts the interconnect's valid/ready request channel into a fixed-latency SRAM bank access and returns read data, plus optional write acknowledges, on the valid/ready response channel. The response path is protected by a credit counter and a response FIFO, so no response is ever dropped under `resp_ready_i` back-pressure.

## Interface
- `NumInLog2`, 5: width of the initiator index.
- `AddrMemWidth`, 12: bank word-address width.
- `DataWidth`, 32: data word width.
- `BeWidth`, DataWidth/8: byte-enable width.
- `MemLatency`, 1: cycles from `mem_req_o` to valid `mem_rdata_i`; must be ≥1.
- `RespDepth`, 2: response FIFO depth and credit limit; must be ≥1; full throughput requires ≥ MemLatency+1.
- `WriteResp`, 1'b0: 1 = writes return an acknowledge response (rdata = 0); 0 = writes return no response.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: one clock; reset is synchronous and active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request ready.
- `req_ini_addr_i` in NumInLog2: requesting initiator.
- `req_tgt_addr_i` in AddrMemWidth: bank word address.
- `req_wen_i` in 1: write enable.
- `req_wdata_i` in DataWidth: write data.
- `req_be_i` in BeWidth: byte enable.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: response ready.
- `resp_ini_addr_o` out NumInLog2: initiator the response is routed to.
- `resp_rdata_o` out DataWidth: read data.
- `mem_req_o` out 1: bank access strobe.
- `mem_we_o` out 1: bank write.
- `mem_addr_o` out AddrMemWidth: bank address.
- `mem_wdata_o` out DataWidth: bank write data.
- `mem_be_o` out BeWidth: bank byte enable.
- `mem_rdata_i` in DataWidth: bank read data, valid MemLatency cycles after the access.

## Operation
- Accept: the handshake is `req_valid_i & req_ready_o`. `mem_req_o` equals the handshake. `mem_we_o`, `mem_addr_o`, `mem_wdata_o` and `mem_be_o` are combinational pass-throughs of the request fields.
- A request needs a response if it is a read, or if it is a write and WriteResp = 1.
- Credit counter `cnt` (0..RespDepth) counts responses owed: in flight in the pipeline plus held in the FIFO.
  - +1 on an accepted request that needs a response.
  - −1 on a response handshake.
  - Both events in the same cycle: no change.
- `req_ready_o = !rst_i && cnt < RespDepth`. It never depends on `req_valid_i`, the payload, or `resp_ready_i`.
- Metadata pipeline: MemLatency stages of {needs_resp, is_write, ini_addr}, aligned with the bank latency. Stage-out valid is called `ret`.
- Return data is `mem_rdata_i` for reads and 0 for acknowledged writes.
- Response FIFO (RespDepth entries of {ini_addr, data}) with fall-through:
  - FIFO empty and `ret` high: `ret` drives the outputs combinationally. If `resp_ready_i` is also high, the FIFO is not written.
  - Otherwise, `ret` pushes into the FIFO tail and the outputs show the FIFO head.
  - Push and pop in the same cycle are legal.
- Overflow is impossible by construction; the bench asserts `!(push && full)`.
- Responses are delivered in acceptance order. `resp_valid_o`, once high, stays high with stable payload until the handshake.

## Timing
- Reset (`rst_i` high at a clock edge): `cnt` = 0, FIFO empty, all pipeline valids = 0.
- Outputs while and after reset: `resp_valid_o` = 0, `resp_ini_addr_o` = 0, `resp_rdata_o` = 0, `mem_req_o` = 0, `req_ready_o` = 0 during reset and 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight and queued responses. Bank accesses already issued are not cancelled.
- Latency: a read accepted in cycle t gives `resp_valid_o` in cycle t+MemLatency when the FIFO is empty; otherwise the response waits behind earlier ones.
- Throughput: with RespDepth ≥ MemLatency+1 and `resp_ready_i` held at 1, one request is accepted per cycle.
- Stall: with `resp_ready_i` = 0, `req_ready_o` falls once `cnt` = RespDepth. It rises in the cycle after the first response handshake.
- Writes with WriteResp = 0 consume no credit but still see `req_ready_o` low when `cnt` = RespDepth.

## Test plan
All scenarios use defaults unless stated.
- Back-to-back reads A=0x10, 0x11, 0x12 from initiators 3, 4, 5, `resp_ready_i` = 1 → `mem_req_o` high 3 cycles; responses in cycles t+1..t+3 with ini 3/4/5 and the bank data; `req_ready_o` stays 1.
- Back-pressure: `resp_ready_i` = 0, 4 reads offered → 2 accepted, `req_ready_o` = 0 from the 3rd cycle; raise `resp_ready_i` → both responses in order, `req_ready_o` = 1 the cycle after the first pop; remaining reads are then accepted.
- Writes with WriteResp = 0: 8 back-to-back writes with `resp_ready_i` = 0 → all accepted, `mem_we_o` = 1, no `resp_valid_o`. Repeat with WriteResp = 1 → 2 accepted, acknowledges with rdata = 0.
- Simultaneous accept and pop with `cnt` = 1 → `cnt` stays 1; FIFO push and pop occur in the same cycle without data loss.
- Reset mid-operation: reset asserted with `cnt` = 2 and the FIFO holding 1 entry → next cycle `resp_valid_o` = 0, `req_ready_o` = 1, `cnt` = 0.
- MemLatency = 3, RespDepth = 4, random valid/ready for 10k cycles → every response matches a scoreboard in order; `cnt` never exceeds 4.

Source files
------------

// File: rtl/tcdm_bank_adapter.sv
// tcdm_bank_adapter: target-side adapter from the interconnect's valid/ready
// request channel to a fixed-latency SRAM bank, with a credit-protected response FIFO.
module tcdm_bank_adapter #(
    parameter int unsigned NumInLog2    = 5,
    parameter int unsigned AddrMemWidth = 12,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned BeWidth      = DataWidth / 8,
    parameter int unsigned MemLatency   = 1,
    parameter int unsigned RespDepth    = 2,
    parameter logic        WriteResp    = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [NumInLog2-1:0]    req_ini_addr_i,
    input  logic [AddrMemWidth-1:0] req_tgt_addr_i,
    input  logic                    req_wen_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [BeWidth-1:0]      req_be_i,

    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [NumInLog2-1:0]    resp_ini_addr_o,
    output logic [DataWidth-1:0]    resp_rdata_o,

    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [AddrMemWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [BeWidth-1:0]      mem_be_o,
    input  logic [DataWidth-1:0]    mem_rdata_i
);

    localparam int unsigned CntWidth = $clog2(RespDepth + 1);
    localparam int unsigned PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(RespDepth);
    localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(RespDepth - 1);

    // Credits: responses owed, either in the bank pipeline or parked in the FIFO.
    logic [CntWidth-1:0] cnt;

    logic req_hs;
    logic needs_resp;
    logic resp_hs;
    logic cnt_inc;
    logic cnt_dec;

    // Metadata travelling alongside the bank access.
    logic [MemLatency-1:0] pipe_v;
    logic [MemLatency-1:0] pipe_w;
    logic [NumInLog2-1:0]  pipe_ini [MemLatency];

    logic                 ret;
    logic                 ret_w;
    logic [NumInLog2-1:0] ret_ini;
    logic [DataWidth-1:0] ret_data;

    // Response FIFO storage and bookkeeping.
    logic [NumInLog2-1:0] fifo_ini  [RespDepth];
    logic [DataWidth-1:0] fifo_data [RespDepth];
    logic [PtrWidth-1:0]  rd_ptr;
    logic [PtrWidth-1:0]  wr_ptr;
    logic [CntWidth-1:0]  fifo_cnt;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;

    function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on the credit count, so it cannot form a comb loop
    // with the initiator's valid or with the response side.
    assign req_ready_o = !rst_i && (cnt < CntMax);
    assign req_hs      = req_valid_i && req_ready_o;
    assign needs_resp  = !req_wen_i || WriteResp;

    assign mem_req_o   = req_hs;
    assign mem_we_o    = req_wen_i;
    assign mem_addr_o  = req_tgt_addr_i;
    assign mem_wdata_o = req_wdata_i;
    assign mem_be_o    = req_be_i;

    assign ret      = pipe_v[MemLatency-1];
    assign ret_w    = pipe_w[MemLatency-1];
    assign ret_ini  = pipe_ini[MemLatency-1];
    assign ret_data = ret_w ? '0 : mem_rdata_i;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CntMax);

    assign resp_valid_o = !rst_i && (ret || !fifo_empty);
    assign resp_hs      = resp_valid_o && resp_ready_i;

    // A returning response bypasses the FIFO only when nothing is queued
    // ahead of it and the initiator takes it right away.
    assign push = ret && !(fifo_empty && resp_ready_i);
    assign pop  = resp_hs && !fifo_empty;

    assign cnt_inc = req_hs && needs_resp;
    assign cnt_dec = resp_hs;

    // Response mux: FIFO head has priority to keep acceptance order.
    always_comb begin
        resp_ini_addr_o = '0;
        resp_rdata_o    = '0;
        if (!rst_i) begin
            if (!fifo_empty) begin
                resp_ini_addr_o = fifo_ini[rd_ptr];
                resp_rdata_o    = fifo_data[rd_ptr];
            end else if (ret) begin
                resp_ini_addr_o = ret_ini;
                resp_rdata_o    = ret_data;
            end
        end
    end

    // Credit counter; simultaneous grant and return cancel out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (cnt_inc && !cnt_dec) begin
            cnt <= cnt + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Valid bits of the metadata pipeline; only response-owing requests enter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= cnt_inc;
            for (int i = 1; i < MemLatency; i++) begin
                pipe_v[i] <= pipe_v[i-1];
            end
        end
    end

    // Metadata payload; qualified by pipe_v so it needs no reset.
    always_ff @(posedge clk_i) begin
        pipe_w[0]   <= req_wen_i;
        pipe_ini[0] <= req_ini_addr_i;
        for (int i = 1; i < MemLatency; i++) begin
            pipe_w[i]   <= pipe_w[i-1];
            pipe_ini[i] <= pipe_ini[i-1];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    // FIFO storage; entries are only read while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_ini[wr_ptr]  <= ret_ini;
            fifo_data[wr_ptr] <= ret_data;
        end
    end

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
// tb_tcdm_bank_adapter: directed and random checks of tcdm_bank_adapter
// with a queue scoreboard per instance (defaults, and ML=3/RD=4/WriteResp=1).
module tb_tcdm_bank_adapter;

    localparam int NI = 5;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = 4;

    typedef struct packed {
        logic [NI-1:0] ini;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic rst;

    logic          a_req_valid, a_req_ready, a_wen;
    logic [NI-1:0] a_ini, a_resp_ini;
    logic [AW-1:0] a_addr, a_mem_addr;
    logic [DW-1:0] a_wdata, a_resp_rdata, a_mem_wdata, a_mem_rdata;
    logic [BW-1:0] a_be, a_mem_be;
    logic          a_resp_valid, a_resp_ready, a_mem_req, a_mem_we;

    logic          b_req_valid, b_req_ready, b_wen;
    logic [NI-1:0] b_ini, b_resp_ini;
    logic [AW-1:0] b_addr, b_mem_addr;
    logic [DW-1:0] b_wdata, b_resp_rdata, b_mem_wdata, b_mem_rdata;
    logic [BW-1:0] b_be, b_mem_be;
    logic          b_resp_valid, b_resp_ready, b_mem_req, b_mem_we;

    exp_t qa[$];
    exp_t qb[$];

    tcdm_bank_adapter dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
        .req_ini_addr_i(a_ini), .req_tgt_addr_i(a_addr),
        .req_wen_i(a_wen), .req_wdata_i(a_wdata), .req_be_i(a_be),
        .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready),
        .resp_ini_addr_o(a_resp_ini), .resp_rdata_o(a_resp_rdata),
        .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_be_o(a_mem_be), .mem_rdata_i(a_mem_rdata)
    );

    tcdm_bank_adapter #(
        .MemLatency(3), .RespDepth(4), .WriteResp(1'b1)
    ) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .req_ini_addr_i(b_ini), .req_tgt_addr_i(b_addr),
        .req_wen_i(b_wen), .req_wdata_i(b_wdata), .req_be_i(b_be),
        .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
        .resp_ini_addr_o(b_resp_ini), .resp_rdata_o(b_resp_rdata),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be), .mem_rdata_i(b_mem_rdata)
    );

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        return {4'hA, a, 4'h5, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bank models: read data appears MemLatency cycles after the access.
    always @(posedge clk)
        a_mem_rdata <= (a_mem_req && !a_mem_we) ? rd_fn(a_mem_addr) : 32'hDEAD_BEEF;

    logic [DW-1:0] b_dly [3];
    always @(posedge clk) begin
        b_dly[0] <= (b_mem_req && !b_mem_we) ? rd_fn(b_mem_addr) : 32'hDEAD_BEEF;
        b_dly[1] <= b_dly[0];
        b_dly[2] <= b_dly[1];
    end
    assign b_mem_rdata = b_dly[2];

    // Scoreboard / invariant monitor for instance A.
    logic          a_pv, a_pr;
    logic [NI-1:0] a_pini;
    logic [DW-1:0] a_pdata;
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            a_pv <= 1'b0;
        end else begin
            if (a_req_valid && a_req_ready && !a_wen)
                qa.push_back('{a_ini, rd_fn(a_addr)});
            if (a_resp_valid && a_resp_ready) begin
                if (qa.size() == 0) begin
                    chk("a_spurious_resp", a_resp_valid, 1'b0);
                end else begin
                    chk("a_sb_ini", a_resp_ini, qa[0].ini);
                    chk("a_sb_data", a_resp_rdata, qa[0].data);
                    void'(qa.pop_front());
                end
            end
            if (a_pv && !a_pr) begin
                chk("a_hold_valid", a_resp_valid, 1'b1);
                chk("a_hold_ini", a_resp_ini, a_pini);
                chk("a_hold_data", a_resp_rdata, a_pdata);
            end
            chk("a_no_overflow", dut_a.push && dut_a.fifo_full, 1'b0);
            a_pv    <= a_resp_valid;
            a_pr    <= a_resp_ready;
            a_pini  <= a_resp_ini;
            a_pdata <= a_resp_rdata;
        end
    end

    // Scoreboard / invariant monitor for instance B.
    logic          b_pv, b_pr;
    logic [NI-1:0] b_pini;
    logic [DW-1:0] b_pdata;
    always @(negedge clk) begin
        if (rst) begin
            qb.delete();
            b_pv <= 1'b0;
        end else begin
            if (b_req_valid && b_req_ready)
                qb.push_back('{b_ini, b_wen ? 32'h0 : rd_fn(b_addr)});
            if (b_resp_valid && b_resp_ready) begin
                if (qb.size() == 0) begin
                    chk("b_spurious_resp", b_resp_valid, 1'b0);
                end else begin
                    chk("b_sb_ini", b_resp_ini, qb[0].ini);
                    chk("b_sb_data", b_resp_rdata, qb[0].data);
                    void'(qb.pop_front());
                end
            end
            if (b_pv && !b_pr) begin
                chk("b_hold_valid", b_resp_valid, 1'b1);
                chk("b_hold_ini", b_resp_ini, b_pini);
                chk("b_hold_data", b_resp_rdata, b_pdata);
            end
            chk("b_no_overflow", dut_b.push && dut_b.fifo_full, 1'b0);
            chk("b_cnt_le_4", dut_b.cnt <= 4, 1'b1);
            b_pv    <= b_resp_valid;
            b_pr    <= b_resp_ready;
            b_pini  <= b_resp_ini;
            b_pdata <= b_resp_rdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic a_rd(input logic [AW-1:0] addr, input logic [NI-1:0] ini);
        a_req_valid = 1'b1;
        a_wen       = 1'b0;
        a_addr      = addr;
        a_ini       = ini;
    endtask

    logic b_acc;

    initial begin
        rst = 1'b1;
        a_req_valid = 0; a_wen = 0; a_ini = '0; a_addr = '0;
        a_wdata = '0; a_be = '1; a_resp_ready = 0;
        b_req_valid = 0; b_wen = 0; b_ini = '0; b_addr = '0;
        b_wdata = '0; b_be = '1; b_resp_ready = 0;
        b_acc = 0;

        // Reset: outputs quiet even with a request offered.
        repeat (2) step();
        a_rd(12'h001, 5'd1);
        neg();
        chk("rst_resp_valid", a_resp_valid, 1'b0);
        chk("rst_req_ready", a_req_ready, 1'b0);
        chk("rst_mem_req", a_mem_req, 1'b0);
        chk("rst_resp_ini", a_resp_ini, 5'd0);
        chk("rst_resp_rdata", a_resp_rdata, 32'd0);
        step();
        rst = 1'b0;
        a_req_valid = 1'b0;
        neg();
        chk("post_rst_ready_a", a_req_ready, 1'b1);
        chk("post_rst_ready_b", b_req_ready, 1'b1);
        chk("post_rst_valid", a_resp_valid, 1'b0);

        // Back-to-back reads, initiator always ready.
        step(); a_resp_ready = 1; a_rd(12'h010, 5'd3); neg();
        chk("b2b_mem_req0", a_mem_req, 1'b1);
        chk("b2b_ready0", a_req_ready, 1'b1);
        chk("b2b_valid0", a_resp_valid, 1'b0);
        step(); a_rd(12'h011, 5'd4); neg();
        chk("b2b_mem_req1", a_mem_req, 1'b1);
        chk("b2b_valid1", a_resp_valid, 1'b1);
        chk("b2b_ini1", a_resp_ini, 5'd3);
        chk("b2b_data1", a_resp_rdata, rd_fn(12'h010));
        step(); a_rd(12'h012, 5'd5); neg();
        chk("b2b_ready2", a_req_ready, 1'b1);
        chk("b2b_ini2", a_resp_ini, 5'd4);
        chk("b2b_data2", a_resp_rdata, rd_fn(12'h011));
        step(); a_req_valid = 0; neg();
        chk("b2b_mem_req3", a_mem_req, 1'b0);
        chk("b2b_ini3", a_resp_ini, 5'd5);
        chk("b2b_data3", a_resp_rdata, rd_fn(12'h012));
        step(); neg();
        chk("b2b_idle", a_resp_valid, 1'b0);

        // Back-pressure: two credits, then stall until the first pop.
        step(); a_resp_ready = 0; a_rd(12'h020, 5'd6); neg();
        chk("bp_acc0", a_mem_req, 1'b1);
        step(); a_rd(12'h021, 5'd7); neg();
        chk("bp_ready1", a_req_ready, 1'b1);
        chk("bp_valid1", a_resp_valid, 1'b1);
        step(); a_rd(12'h022, 5'd8); neg();
        chk("bp_ready2", a_req_ready, 1'b0);
        chk("bp_mem_req2", a_mem_req, 1'b0);
        step(); neg();
        chk("bp_ready3", a_req_ready, 1'b0);
        chk("bp_ini3", a_resp_ini, 5'd6);
        step(); a_resp_ready = 1; neg();
        chk("bp_ready_at_pop", a_req_ready, 1'b0);
        chk("bp_ini_pop", a_resp_ini, 5'd6);
        step(); neg();
        chk("bp_ready_after_pop", a_req_ready, 1'b1);
        chk("bp_acc_after_pop", a_mem_req, 1'b1);
        chk("bp_cnt_before", dut_a.cnt, 2'd1);
        chk("bp_ini_second", a_resp_ini, 5'd7);
        step(); a_rd(12'h023, 5'd9); neg();
        chk("bp_cnt_same", dut_a.cnt, 2'd1);
        chk("bp_ini_third", a_resp_ini, 5'd8);
        step(); a_req_valid = 0; neg();
        chk("bp_ini_fourth", a_resp_ini, 5'd9);
        step(); neg();
        chk("bp_idle", a_resp_valid, 1'b0);

        // FIFO push and pop in the same cycle.
        step(); a_resp_ready = 0; a_rd(12'h030, 5'd10); neg();
        step(); a_rd(12'h031, 5'd11); neg();
        chk("pp_ini0", a_resp_ini, 5'd10);
        step(); a_req_valid = 0; a_resp_ready = 1; neg();
        chk("pp_push", dut_a.push, 1'b1);
        chk("pp_pop", dut_a.pop, 1'b1);
        chk("pp_ini1", a_resp_ini, 5'd10);
        step(); neg();
        chk("pp_ini2", a_resp_ini, 5'd11);
        chk("pp_data2", a_resp_rdata, rd_fn(12'h031));
        step(); neg();
        chk("pp_idle", a_resp_valid, 1'b0);

        // Writes without acknowledge: no credit, no response.
        a_resp_ready = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            a_req_valid = 1; a_wen = 1;
            a_addr = AW'(12'h040 + i);
            a_wdata = $urandom;
            a_be = BW'(i);
            neg();
            chk("wr_ready", a_req_ready, 1'b1);
            chk("wr_mem_we", a_mem_we, 1'b1);
            chk("wr_mem_wdata", a_mem_wdata, a_wdata);
            chk("wr_no_resp", a_resp_valid, 1'b0);
        end
        step(); a_req_valid = 0; a_wen = 0; neg();
        chk("wr_idle", a_resp_valid, 1'b0);

        // A write still stalls when credits are exhausted.
        step(); a_rd(12'h050, 5'd12); neg();
        step(); a_rd(12'h051, 5'd13); neg();
        step(); a_wen = 1; a_addr = 12'h052; neg();
        chk("wr_stall_ready", a_req_ready, 1'b0);
        chk("wr_stall_mem_req", a_mem_req, 1'b0);
        step(); a_req_valid = 0; a_wen = 0; a_resp_ready = 1; neg();
        step(); neg();
        step(); neg();
        chk("wr_stall_drained", a_resp_valid, 1'b0);

        // Reset with responses in flight and queued.
        step(); a_resp_ready = 0; a_rd(12'h060, 5'd14); neg();
        step(); a_rd(12'h061, 5'd15); neg();
        step(); a_req_valid = 0; rst = 1; neg();
        chk("mr_cnt_pre", dut_a.cnt, 2'd2);
        chk("mr_fifo_pre", dut_a.fifo_cnt, 2'd1);
        chk("mr_valid_in_rst", a_resp_valid, 1'b0);
        step(); rst = 0; neg();
        chk("mr_valid_after", a_resp_valid, 1'b0);
        chk("mr_ready_after", a_req_ready, 1'b1);
        chk("mr_cnt_after", dut_a.cnt, 2'd0);

        // B: acknowledged writes consume credits, four deep.
        for (int i = 0; i < 5; i++) begin
            step();
            b_req_valid = 1; b_wen = 1;
            b_addr = AW'(i); b_ini = NI'(i + 16);
            b_wdata = $urandom;
            neg();
            chk("b_wr_ready", b_req_ready, (i < 4) ? 1'b1 : 1'b0);
        end
        step(); b_req_valid = 0; b_wen = 0; b_resp_ready = 1;
        repeat (8) step();
        neg();
        chk("b_wr_drained", qb.size(), 0);

        // B: random traffic, request held until accepted.
        b_acc = 0;
        for (int c = 0; c < 10000; c++) begin
            step();
            if (!b_req_valid || b_acc) begin
                b_req_valid = ($urandom_range(0, 3) != 0);
                b_wen = 1'($urandom_range(0, 1));
                b_addr = AW'($urandom);
                b_ini = NI'($urandom);
                b_wdata = $urandom;
                b_be = BW'($urandom);
            end
            b_resp_ready = ($urandom_range(0, 2) != 0);
            neg();
            b_acc = b_req_valid && b_req_ready;
        end
        step(); b_req_valid = 0; b_resp_ready = 1;
        repeat (12) step();
        neg();
        chk("b_rand_drained", qb.size(), 0);
        chk("a_final_empty", qa.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
